// File: rtl/mem_io_responder.sv
// Byte-bus slave beside the CPU core: 128KB RAM plus an I/O window at 0x3xxxx
// holding the UART TX/RX FIFOs, a free-running cycle counter and the program-stop flag.
module mem_io_responder #(
    parameter int RAM_AW      = 17,
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        sim_done,
    output logic        tx_overflow
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_LVL = (TX_AW+1)'(TX_DEPTH - FULL_MARGIN);

    // ---------------- address decode ----------------
    logic w_io;
    logic w_sel_uart;
    logic w_sel_cnt;
    logic w_sel_snap;
    logic w_rd;
    logic w_unused;

    assign w_io       = (cpu_a[17:16] == 2'b11);
    assign w_sel_uart = w_io && (cpu_a[15:0] == 16'h0000);
    assign w_sel_cnt  = w_io && (cpu_a[15:0] == 16'h0004);
    assign w_sel_snap = w_io && (cpu_a[15:2] == 14'h0001) && (cpu_a[1:0] != 2'b00);
    assign w_rd       = !cpu_wr;
    assign w_unused   = &{1'b0, cpu_a[31:18]};

    // ---------------- RAM ----------------
    logic [7:0] r_ram [2**RAM_AW];
    logic [7:0] r_ram_q;

    // Kept free of reset so it maps onto block RAM; the output mux below masks it after reset.
    always_ff @(posedge clk_in) begin
        if (cpu_wr && !w_io)
            r_ram[cpu_a[RAM_AW-1:0]] <= cpu_din;
        if (w_rd && !w_io)
            r_ram_q <= r_ram[cpu_a[RAM_AW-1:0]];
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]     r_tx_mem [TX_DEPTH];
    logic [TX_AW:0] r_tx_wp;
    logic [TX_AW:0] r_tx_rp;
    logic [TX_AW:0] w_tx_wp_nxt;
    logic [TX_AW:0] w_tx_rp_nxt;
    logic [TX_AW:0] w_tx_cnt_nxt;
    logic           w_tx_empty;
    logic           w_tx_full;
    logic           w_tx_req;
    logic           w_tx_push;
    logic           w_tx_pop;
    logic [7:0]     w_tx_byte;
    logic           r_io_full;
    logic           r_tx_ovf;

    assign w_tx_empty   = (r_tx_wp == r_tx_rp);
    assign w_tx_full    = (r_tx_wp[TX_AW] != r_tx_rp[TX_AW]) &&
                          (r_tx_wp[TX_AW-1:0] == r_tx_rp[TX_AW-1:0]);
    assign w_tx_pop     = !w_tx_empty && tx_ready;
    assign w_tx_req     = cpu_wr && ((w_sel_uart && (cpu_din != 8'h00)) || w_sel_cnt);
    assign w_tx_byte    = w_sel_cnt ? 8'h00 : cpu_din;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_tx_push    = w_tx_req && (!w_tx_full || w_tx_pop);
    assign w_tx_wp_nxt  = r_tx_wp + (TX_AW+1)'(w_tx_push);
    assign w_tx_rp_nxt  = r_tx_rp + (TX_AW+1)'(w_tx_pop);
    assign w_tx_cnt_nxt = w_tx_wp_nxt - w_tx_rp_nxt;

    always_ff @(posedge clk_in) begin
        if (w_tx_push)
            r_tx_mem[r_tx_wp[TX_AW-1:0]] <= w_tx_byte;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_tx_wp   <= '0;
            r_tx_rp   <= '0;
            r_io_full <= 1'b0;
            r_tx_ovf  <= 1'b0;
        end else begin
            r_tx_wp   <= w_tx_wp_nxt;
            r_tx_rp   <= w_tx_rp_nxt;
            r_io_full <= (w_tx_cnt_nxt >= TX_FULL_LVL);
            if (w_tx_req && !w_tx_push)
                r_tx_ovf <= 1'b1;
        end
    end

    assign tx_valid       = !w_tx_empty;
    assign tx_data        = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rp[TX_AW-1:0]];
    assign io_buffer_full = r_io_full;
    assign tx_overflow    = r_tx_ovf;

    // ---------------- RX FIFO ----------------
    logic [7:0]     r_rx_mem [RX_DEPTH];
    logic [RX_AW:0] r_rx_wp;
    logic [RX_AW:0] r_rx_rp;
    logic           w_rx_empty;
    logic           w_rx_full;
    logic           w_rx_push;
    logic           w_rx_pop;
    logic [7:0]     w_rx_head;

    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp[RX_AW] != r_rx_rp[RX_AW]) &&
                        (r_rx_wp[RX_AW-1:0] == r_rx_rp[RX_AW-1:0]);
    assign w_rx_push  = rx_valid && !w_rx_full;
    assign w_rx_pop   = w_rd && w_sel_uart && !w_rx_empty;
    assign w_rx_head  = r_rx_mem[r_rx_rp[RX_AW-1:0]];
    assign rx_ready   = !w_rx_full;

    always_ff @(posedge clk_in) begin
        if (w_rx_push)
            r_rx_mem[r_rx_wp[RX_AW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else begin
            r_rx_wp <= r_rx_wp + (RX_AW+1)'(w_rx_push);
            r_rx_rp <= r_rx_rp + (RX_AW+1)'(w_rx_pop);
        end
    end

    // ---------------- counter, read mux, stop flag ----------------
    logic [31:0] r_cnt;
    logic [23:0] r_snap;
    logic [7:0]  r_io_q;
    logic        r_src_ram;
    logic        r_done;
    logic [7:0]  w_io_rd;

    always_comb begin
        w_io_rd = 8'h00;
        if (w_sel_uart) begin
            w_io_rd = w_rx_empty ? 8'h00 : w_rx_head;
        end else if (w_sel_cnt) begin
            w_io_rd = r_cnt[7:0];
        end else if (w_sel_snap) begin
            case (cpu_a[1:0])
                2'd1:    w_io_rd = r_snap[7:0];
                2'd2:    w_io_rd = r_snap[15:8];
                default: w_io_rd = r_snap[23:16];
            endcase
        end
    end

    // Reading the low counter byte freezes the upper bytes so a 4-byte read is coherent.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cnt     <= '0;
            r_snap    <= '0;
            r_io_q    <= 8'h00;
            r_src_ram <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
            if (w_rd) begin
                r_src_ram <= !w_io;
                r_io_q    <= w_io_rd;
                if (w_sel_cnt)
                    r_snap <= r_cnt[31:8];
            end
            if (cpu_wr && w_sel_cnt)
                r_done <= 1'b1;
        end
    end

    assign cpu_dout = r_src_ram ? r_ram_q : r_io_q;
    assign sim_done = r_done;

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomised scoreboard bench for mem_io_responder against a queue-based model
// of the RAM, UART FIFOs, cycle counter and sticky flags.
module tb_mem_io_responder;
    localparam int TXD    = 16;
    localparam int RXD    = 16;
    localparam int MARGIN = 2;
    localparam logic [31:0] IDLE_A = 32'h0003_FFF0;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] cpu_a = '0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_din = '0;
    logic [7:0]  cpu_dout;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        sim_done;
    logic        tx_overflow;

    always #5 clk_in = ~clk_in;

    mem_io_responder #(.RAM_AW(17), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .FULL_MARGIN(MARGIN)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .io_buffer_full(io_buffer_full), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .sim_done(sim_done), .tx_overflow(tx_overflow)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model
    typedef struct { int due; logic [7:0] val; } rd_t;
    logic [7:0]  ram_m [int];
    logic [7:0]  rx_m [$];
    logic [7:0]  exp_tx [$];
    rd_t         rd_q [$];
    int          tx_cnt = 0;
    int unsigned cnt_m = 0;
    int unsigned snap_m = 0;
    bit          done_m = 0;
    bit          ovf_m = 0;
    int          edges = 0;

    logic [31:0] ram_addrs [7] = '{32'h0000_0000, 32'h0000_0123, 32'h0001_FFFF, 32'h0000_ABCD,
                                   32'h0002_FFFF, 32'h0000_FFFF, 32'hFFF0_0123};

    task automatic tx_push_m(input logic [7:0] d, input bit pop);
        if (tx_cnt < TXD || pop) begin
            tx_cnt++;
            exp_tx.push_back(d);
        end else begin
            ovf_m = 1;
        end
    endtask

    task automatic cycle(input bit wr, input logic [31:0] a, input logic [7:0] d,
                         input bit rdy, input bit rxv, input logic [7:0] rxd);
        bit         io;
        bit         tx_pop;
        bit         rx_push;
        logic [7:0] v;
        rd_t        e;
        cpu_wr = wr; cpu_a = a; cpu_din = d;
        tx_ready = rdy; rx_valid = rxv; rx_data = rxd;
        if (rst_in) begin
            io      = (a[17:16] == 2'b11);
            tx_pop  = (tx_cnt > 0) && rdy;
            rx_push = rxv && (rx_m.size() < RXD);
            chk("rx_ready", rx_ready, rx_m.size() < RXD);
            if (wr) begin
                if (!io) ram_m[int'(a[16:0])] = d;
                else if (a[17:0] == 18'h30000 && d != 8'h00) tx_push_m(d, tx_pop);
                else if (a[17:0] == 18'h30004) begin
                    tx_push_m(8'h00, tx_pop);
                    done_m = 1;
                end
            end else begin
                v = 8'h00;
                if (!io) v = ram_m.exists(int'(a[16:0])) ? ram_m[int'(a[16:0])] : 8'h00;
                else if (a[17:0] == 18'h30000) v = (rx_m.size() > 0) ? rx_m.pop_front() : 8'h00;
                else if (a[17:0] == 18'h30004) begin
                    v = cnt_m[7:0];
                    snap_m = cnt_m >> 8;
                end
                else if (a[17:0] == 18'h30005) v = snap_m[7:0];
                else if (a[17:0] == 18'h30006) v = snap_m[15:8];
                else if (a[17:0] == 18'h30007) v = snap_m[23:16];
                e.due = edges + 1;
                e.val = v;
                rd_q.push_back(e);
            end
            if (tx_pop) tx_cnt--;
            if (rx_push) rx_m.push_back(rxd);
            cnt_m++;
        end
        @(posedge clk_in);
        edges++;
        #1;
        if (rst_in) begin
            chk("io_buffer_full", io_buffer_full, tx_cnt >= TXD - MARGIN);
            chk("tx_valid", tx_valid, tx_cnt > 0);
            chk("sim_done", sim_done, done_m);
            chk("tx_overflow", tx_overflow, ovf_m);
        end
    endtask

    task automatic idle(input bit rdy);
        cycle(1, IDLE_A, 8'h00, rdy, 0, 8'h00);
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        #1;
        rd_q.delete(); exp_tx.delete(); rx_m.delete();
        tx_cnt = 0; cnt_m = 0; snap_m = 0; done_m = 0; ovf_m = 0;
        chk("rst_cpu_dout", cpu_dout, 8'h00);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_io_full", io_buffer_full, 0);
        chk("rst_sim_done", sim_done, 0);
        chk("rst_tx_overflow", tx_overflow, 0);
        chk("rst_rx_ready", rx_ready, 1);
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
    endtask

    // Monitor: read data one edge after the read; TX bytes on each handshake
    initial begin
        rd_t e;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                while (rd_q.size() > 0 && rd_q[0].due <= edges) begin
                    e = rd_q.pop_front();
                    chk("cpu_dout", cpu_dout, e.val);
                end
                if (tx_valid && tx_ready) begin
                    if (exp_tx.size() == 0) chk("tx_spurious", tx_valid, 0);
                    else chk("tx_data", tx_data, exp_tx.pop_front());
                end
            end
        end
    end

    task automatic random_phase(input int n);
        int         op;
        bit         rdy;
        bit         rxv;
        logic [7:0] rxd;
        logic [7:0] d;
        logic [31:0] ra;
        for (int i = 0; i < n; i++) begin
            op  = $urandom_range(0, 9);
            rdy = ($urandom_range(0, 9) < 6);
            rxv = ($urandom_range(0, 9) < 4);
            rxd = 8'($urandom);
            d   = 8'($urandom);
            ra  = ram_addrs[$urandom_range(0, 6)];
            case (op)
                0, 1: cycle(1, ra, d, rdy, rxv, rxd);
                2, 3: cycle(0, ra, d, rdy, rxv, rxd);
                4:    cycle(1, 32'h0003_0000, ($urandom_range(0, 3) == 0) ? 8'h00 : d, rdy, rxv, rxd);
                5, 6: cycle(0, 32'h0003_0000, d, rdy, rxv, rxd);
                7:    cycle(0, 32'h0003_0004 + 32'($urandom_range(0, 3)), d, rdy, rxv, rxd);
                8:    cycle(0, 32'hABC3_0010, d, rdy, rxv, rxd);
                default: begin
                    if ($urandom_range(0, 7) == 0) cycle(1, 32'h0003_0004, d, rdy, rxv, rxd);
                    else cycle(1, 32'h0003_0006, d, rdy, rxv, rxd);
                end
            endcase
        end
    endtask

    initial begin
        #2;
        do_reset();

        // RAM write then immediate read-back, then seed every random-phase address
        cycle(1, 32'h0000_0123, 8'hA5, 0, 0, 8'h00);
        cycle(0, 32'h0000_0123, 8'h00, 0, 0, 8'h00);
        for (int i = 0; i < 7; i++) cycle(1, ram_addrs[i], 8'(8'h10 + i), 0, 0, 8'h00);
        for (int i = 0; i < 7; i++) cycle(0, ram_addrs[i], 8'h00, 0, 0, 8'h00);

        // "Hi" then a zero byte that must not be queued
        cycle(1, 32'h0003_0000, 8'h48, 1, 0, 8'h00);
        cycle(1, 32'h0003_0000, 8'h69, 1, 0, 8'h00);
        cycle(1, 32'h0003_0000, 8'h00, 1, 0, 8'h00);
        repeat (4) idle(1);
        chk("hi_drained", exp_tx.size(), 0);

        // Fill TX with the sink stalled: near-full after 14, overflow on 17
        for (int i = 0; i < 17; i++) begin
            cycle(1, 32'h0003_0000, 8'(i + 1), 0, 0, 8'h00);
            if (i == 12) chk("t3_not_full_13", io_buffer_full, 0);
            if (i == 13) chk("t3_full_14", io_buffer_full, 1);
            if (i == 15) chk("t3_no_ovf_16", tx_overflow, 0);
        end
        chk("t3_ovf_17", tx_overflow, 1);
        repeat (20) idle(1);
        chk("t3_drained", exp_tx.size(), 0);

        // RX: two bytes queued, three reads -> 31, 32, 00
        cycle(1, IDLE_A, 8'h00, 1, 1, 8'h31);
        cycle(1, IDLE_A, 8'h00, 1, 1, 8'h32);
        repeat (3) cycle(0, 32'h0003_0000, 8'h00, 1, 0, 8'h00);

        // RX fill to full so rx_ready drops, then drain
        for (int i = 0; i < RXD + 2; i++) cycle(1, IDLE_A, 8'h00, 1, 1, 8'(8'h40 + i));
        chk("rx_full_ready", rx_ready, 0);
        repeat (RXD + 1) cycle(0, 32'h0003_0000, 8'h00, 1, 0, 8'h00);

        random_phase(1500);

        // Program stop: sticky flag, 0x00 emitted, cleared by async reset
        repeat (20) idle(1);
        repeat (RXD + 1) cycle(0, 32'h0003_0000, 8'h00, 1, 0, 8'h00);
        cycle(1, 32'h0003_0004, 8'h5A, 0, 0, 8'h00);
        chk("stop_tx_data", tx_data, 8'h00);
        chk("stop_tx_valid", tx_valid, 1);
        repeat (2) idle(0);
        chk("stop_sticky", sim_done, 1);
        do_reset();

        // Counter snapshot read at 0x1FF
        for (int i = 0; i < 600 && cnt_m != 32'h1FF; i++) idle(1);
        chk("cnt_reach", cnt_m, 32'h1FF);
        for (int i = 0; i < 4; i++) cycle(0, 32'h0003_0004 + 32'(i), 8'h00, 1, 0, 8'h00);
        idle(1);
        chk("ram_retained", 32'(rd_q.size()), 0);
        cycle(0, 32'h0000_0123, 8'h00, 1, 0, 8'h00);
        repeat (3) idle(1);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("tx_q_empty", exp_tx.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
